// File: rtl/pulse_period_checker.sv
`default_nettype none
// ============================================================================
// Module   : pulse_period_checker
// Purpose  : Receive-side health checker for a divide-by-N strobe. Measures
//            the spacing between pulse events, locks after LOCK_COUNT
//            consecutive intervals of exactly PERIOD clocks, and once locked
//            flags early or missing pulses with a one-cycle err pulse and a
//            saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_period_checker #(
  parameter int PERIOD     = 3,  // expected spacing in clocks, 2 .. 2**CNT_W-2
  parameter int LOCK_COUNT = 4,  // consecutive matching intervals to lock, >= 1
  parameter int CNT_W      = 8,  // interval counter / period output width
  parameter int ERR_W      = 8   // saturating error counter width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic [CNT_W-1:0] period,
  output logic             period_valid
);

  // Match counter must hold values 0 .. LOCK_COUNT.
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]   C_PERIOD    = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0]   C_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   C_CNT_MAX   = '1;
  localparam logic [MATCH_W-1:0] C_LOCK      = MATCH_W'(LOCK_COUNT);
  localparam logic [MATCH_W-1:0] C_MATCH_ONE = MATCH_W'(1);
  localparam logic [ERR_W-1:0]   C_ERR_ONE   = ERR_W'(1);
  localparam logic [ERR_W-1:0]   C_ERR_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEAS   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [MATCH_W-1:0] r_match;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [MATCH_W-1:0] w_match_inc;
  logic               w_err_nxt;
  logic               w_pv_nxt;
  logic               w_on_time;

  // The counter equals PERIOD exactly in the cycle a pulse is due; a pulse
  // there is a good interval, silence there is a missing pulse.
  assign w_on_time   = (r_cnt == C_PERIOD);
  assign w_match_inc = r_match + C_MATCH_ONE;

  // Interval counter: restarts at 1 on every pulse event, idles at 0 before
  // the first pulse, otherwise counts up and sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (pulse_in) begin
      r_cnt <= C_CNT_ONE;
    end else if ((r_state != ST_IDLE) && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + C_CNT_ONE;
    end
  end

  // State and match-count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_match <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= w_match_nxt;
    end
  end

  // Next-state, match tracking and the pre-register err/period_valid strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_err_nxt   = 1'b0;
    w_pv_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // First pulse only starts timing; there is no interval to report.
        if (pulse_in) begin
          w_state_nxt = ST_MEAS;
          w_match_nxt = '0;
        end
      end
      ST_MEAS: begin
        if (pulse_in) begin
          w_pv_nxt = 1'b1;
          if (w_on_time) begin
            if (w_match_inc == C_LOCK) begin
              w_state_nxt = ST_LOCKED;
              w_match_nxt = '0;
            end else begin
              w_match_nxt = w_match_inc;
            end
          end else begin
            w_match_nxt = '0;
          end
        end else if (w_on_time) begin
          // Missing pulse breaks the run but is not an error while acquiring.
          w_match_nxt = '0;
        end
      end
      ST_LOCKED: begin
        if (pulse_in) begin
          w_pv_nxt = 1'b1;
          // While locked the counter cannot pass PERIOD without a miss being
          // taken first, so any off-time pulse here is an early one.
          if (!w_on_time) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_MEAS;
            w_match_nxt = '0;
          end
        end else if (w_on_time) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_MEAS;
          w_match_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_match_nxt = '0;
      end
    endcase
  end

  // Registered outputs; locked tracks the state being entered so it is a
  // flop output aligned with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked       <= 1'b0;
      err          <= 1'b0;
      period_valid <= 1'b0;
      period       <= '0;
    end else begin
      locked       <= (w_state_nxt == ST_LOCKED);
      err          <= w_err_nxt;
      period_valid <= w_pv_nxt;
      if (w_pv_nxt) begin
        period <= r_cnt;
      end
    end
  end

  // Saturating count of err pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (w_err_nxt && (err_count != C_ERR_MAX)) begin
      err_count <= err_count + C_ERR_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_period_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_period_checker
// Purpose  : Self-checking bench for pulse_period_checker. Two instances share
//            the stimulus: default widths, and ERR_W=2 for counter saturation.
//            A timestamp-based reference model predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_period_checker;

  localparam int PER = 3;
  localparam int LC  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_in = 1'b0;

  logic       lk_a, err_a, pv_a;
  logic [7:0] ec_a, per_a;
  logic       lk_b, err_b, pv_b;
  logic [1:0] ec_b;
  logic [7:0] per_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: timestamps rather than a counter.
  int t = 0;
  bit m_has_prev = 0;
  int m_last = 0;
  int m_match = 0;
  bit m_lk = 0;
  bit e_lk = 0, e_err = 0, e_pv = 0;
  int e_period = 0, e_ec8 = 0, e_ec2 = 0;

  always #5 clk = ~clk;

  pulse_period_checker #(.PERIOD(PER), .LOCK_COUNT(LC), .CNT_W(8), .ERR_W(8)) u_dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .locked(lk_a), .err(err_a), .err_count(ec_a),
    .period(per_a), .period_valid(pv_a)
  );

  pulse_period_checker #(.PERIOD(PER), .LOCK_COUNT(LC), .CNT_W(8), .ERR_W(2)) u_dut_sat (
    .clk(clk), .reset(reset), .pulse_in(pulse_in),
    .locked(lk_b), .err(err_b), .err_count(ec_b),
    .period(per_b), .period_valid(pv_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  // Predict outputs visible after the clock edge at which (r, p) is sampled.
  task automatic model_update(input bit r, input bit p);
    int gap;
    if (r) begin
      m_has_prev = 0; m_match = 0; m_lk = 0;
      e_err = 0; e_pv = 0; e_period = 0; e_ec8 = 0; e_ec2 = 0;
    end else begin
      gap = 0;
      if (m_has_prev) gap = ((t - m_last) > 255) ? 255 : (t - m_last);
      e_err = 0;
      e_pv  = 0;
      if (p) begin
        if (m_has_prev) begin
          e_pv = 1;
          e_period = gap;
          if (m_lk) begin
            if (gap != PER) begin e_err = 1; m_lk = 0; m_match = 0; end
          end else if (gap == PER) begin
            m_match++;
            if (m_match == LC) begin m_lk = 1; m_match = 0; end
          end else begin
            m_match = 0;
          end
        end
        m_has_prev = 1;
        m_last = t;
      end else if (m_has_prev && gap == PER) begin
        if (m_lk) begin e_err = 1; m_lk = 0; end
        m_match = 0;
      end
      if (e_err) begin
        if (e_ec8 < 255) e_ec8++;
        if (e_ec2 < 3)   e_ec2++;
      end
    end
    e_lk = m_lk;
    t++;
  endtask

  task automatic compare_all();
    chk("locked",       lk_a,  e_lk);
    chk("err",          err_a, e_err);
    chk("period_valid", pv_a,  e_pv);
    chk("period",       per_a, e_period);
    chk("err_count",    ec_a,  e_ec8);
    chk("sat_locked",   lk_b,  e_lk);
    chk("sat_err",      err_b, e_err);
    chk("sat_err_count", ec_b, e_ec2);
    chk("sat_period",   per_b, e_period);
    chk("sat_pv",       pv_b,  e_pv);
  endtask

  // One clock: drive, let the edge happen, update model, sample 1ns later.
  task automatic step(input bit r, input bit p);
    reset = r;
    pulse_in = p;
    @(posedge clk);
    model_update(r, p);
    #1;
    compare_all();
  endtask

  // One pulse followed by LC good intervals: ends locked from any state.
  task automatic lock_up();
    step(0, 1);
    repeat (LC) begin
      step(0, 0); step(0, 0); step(0, 1);
    end
    chk("lock_up_locked", lk_a, 1);
  endtask

  typedef struct {
    bit rst; bit p; bit lk; bit err; bit pv; int per; int ec;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int gaps[7];
    int countdown;
    int r;

    // Pulses at cycles 0,3,..,12, lock, then the pulse due at 15 is omitted.
    tbl.push_back('{1, 0, 0, 0, 0, 0, 0});  // reset
    tbl.push_back('{0, 1, 0, 0, 0, 0, 0});  // c0
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0});  // c1
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0});  // c2
    tbl.push_back('{0, 1, 0, 0, 1, 3, 0});  // c3
    tbl.push_back('{0, 0, 0, 0, 0, 3, 0});  // c4
    tbl.push_back('{0, 0, 0, 0, 0, 3, 0});  // c5
    tbl.push_back('{0, 1, 0, 0, 1, 3, 0});  // c6
    tbl.push_back('{0, 0, 0, 0, 0, 3, 0});  // c7
    tbl.push_back('{0, 0, 0, 0, 0, 3, 0});  // c8
    tbl.push_back('{0, 1, 0, 0, 1, 3, 0});  // c9
    tbl.push_back('{0, 0, 0, 0, 0, 3, 0});  // c10
    tbl.push_back('{0, 0, 0, 0, 0, 3, 0});  // c11
    tbl.push_back('{0, 1, 1, 0, 1, 3, 0});  // c12: 4th match, locked next
    tbl.push_back('{0, 0, 1, 0, 0, 3, 0});  // c13
    tbl.push_back('{0, 0, 1, 0, 0, 3, 0});  // c14
    tbl.push_back('{0, 0, 0, 1, 0, 3, 1});  // c15: missing pulse
    tbl.push_back('{0, 0, 0, 0, 0, 3, 1});  // c16

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].p);
      chk("tbl_locked", lk_a,  tbl[i].lk);
      chk("tbl_err",    err_a, tbl[i].err);
      chk("tbl_pv",     pv_a,  tbl[i].pv);
      chk("tbl_period", per_a, tbl[i].per);
      chk("tbl_errcnt", ec_a,  tbl[i].ec);
    end

    // Extra pulse one cycle after a good pulse while locked, then relock.
    lock_up();
    step(0, 0); step(0, 0); step(0, 1);
    chk("early_pre_locked", lk_a, 1);
    step(0, 1);
    chk("early_period", per_a, 1);
    chk("early_pv",     pv_a, 1);
    chk("early_err",    err_a, 1);
    chk("early_locked", lk_a, 0);
    chk("early_errcnt", ec_a, 2);
    for (int i = 0; i < LC; i++) begin
      step(0, 0); step(0, 0); step(0, 1);
      chk("relock_locked", lk_a, (i == LC - 1) ? 1 : 0);
      chk("relock_err", err_a, 0);
    end

    // Reset while locked with a nonzero error count.
    chk("pre_reset_errcnt_nz", (ec_a != 0) ? 1 : 0, 1);
    step(1, 0);
    chk("rst_locked", lk_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_pv", pv_a, 0);
    chk("rst_period", per_a, 0);
    chk("rst_errcnt", ec_a, 0);
    step(0, 0);
    step(0, 1);
    chk("first_pulse_no_pv", pv_a, 0);
    step(0, 0);
    chk("first_pulse_no_pv2", pv_a, 0);

    // Intervals 3,3,4,3,3,3,3: the 4 restarts the run.
    step(1, 0);
    step(0, 1);
    gaps = '{3, 3, 4, 3, 3, 3, 3};
    for (int i = 0; i < 7; i++) begin
      repeat (gaps[i] - 1) step(0, 0);
      step(0, 1);
      chk("run_locked", lk_a, (i == 6) ? 1 : 0);
      chk("run_err", err_a, 0);
      chk("run_period", per_a, gaps[i]);
    end

    // Five lock/miss cycles: the 2-bit counter saturates at 3.
    step(1, 0);
    for (int k = 0; k < 5; k++) begin
      lock_up();
      step(0, 0); step(0, 0); step(0, 0);
      chk("miss_err", err_a, 1);
      chk("miss_errcnt8", ec_a, k + 1);
      chk("miss_errcnt2", ec_b, (k + 1 > 3) ? 3 : k + 1);
    end
    // Long silence: counter saturates without raising err.
    for (int i = 0; i < 300; i++) begin
      step(0, 0);
      chk("silence_err", err_a, 0);
    end
    step(0, 1);
    chk("sat_interval", per_a, 255);

    // Randomised pulse stream, mostly on-period with jitter and rare resets.
    step(1, 0);
    countdown = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) begin
        step(1, 0);
      end else begin
        countdown--;
        if (countdown <= 0) begin
          r = int'($urandom_range(0, 9));
          countdown = (r < 7) ? PER : int'($urandom_range(1, 8));
          step(0, 1);
        end else begin
          step(0, 0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
